// File: rtl/fresh_msg_codec.sv
// Streaming XOR mask/unmask engine with timestamp freshness gate, optional
// per-word LFSR key roll and a rotate-xor running tag with optional tag check.
module fresh_msg_codec #(
  parameter int          W                = 64,
  parameter int          MAX_WORDS        = 8,
  parameter int unsigned ACCEPTABLE_DELAY = 10,
  parameter logic [W-1:0] HASH_INIT       = {W/8{8'hA5}},
  localparam int         LW               = $clog2(MAX_WORDS+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] msg_len,
  input  logic [W-1:0]  cfg_key,
  input  logic [1:0]    cfg_mode,
  input  logic [W-1:0]  ts_sent,
  input  logic [W-1:0]  ts_now,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  input  logic [W-1:0]  tag_in,
  output logic [W-1:0]  tag_out,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status
);

  // state    | meaning
  // IDLE     | waiting for start
  // CHECK    | freshness compare on latched timestamp delta
  // STREAM   | mask words through single-entry output register
  // TAG      | publish tag, optional compare against tag_in
  // DONE     | one-cycle completion pulse
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_TAG    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_WORDS);
  localparam logic [W-1:0]  DELAY_LIM = W'(ACCEPTABLE_DELAY);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [W-1:0]  key_q, key_d, acc_q, acc_d, delta_q, delta_d;
  logic [W-1:0]  out_data_q, out_data_d, tag_out_q, tag_out_d;
  logic [1:0]    mode_q, mode_d, status_q, status_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic          in_acc, out_acc;
  logic [W-1:0]  masked, mix;

  assign masked   = in_data ^ key_q;
  assign mix      = acc_q ^ masked;
  // Input stalls only when the output register is full and not draining.
  assign in_ready = (state_q == S_STREAM) && (cnt_q != len_q) && (!out_valid_q || out_ready);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign tag_out   = tag_out_q;
  assign status    = status_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    acc_d       = acc_q;
    delta_d     = delta_q;
    mode_d      = mode_q;
    status_d    = status_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    tag_out_d   = tag_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = msg_len;
          key_d    = cfg_key;
          mode_d   = cfg_mode;
          delta_d  = ts_now - ts_sent;
          status_d = 2'b00;
          acc_d    = HASH_INIT;
          cnt_d    = '0;
          if (msg_len == '0 || msg_len > MAX_LEN) begin
            status_d = 2'b11;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (delta_q > DELAY_LIM) begin
          status_d = 2'b01;
          state_d  = S_DONE;
        end else begin
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_acc) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) state_d = S_TAG;
        end
        if (in_acc) begin
          out_data_d  = masked;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == len_q - LW'(1));
          acc_d       = {mix[W-4:0], mix[W-1:W-3]};
          cnt_d       = cnt_q + LW'(1);
          if (mode_q[0])
            key_d = {key_q[W-2:0], key_q[W-1] ^ key_q[W-2] ^ key_q[W-4] ^ key_q[W-5]};
        end
      end
      S_TAG: begin
        tag_out_d = acc_q;
        status_d  = (mode_q[1] && (tag_in != acc_q)) ? 2'b10 : 2'b00;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      acc_q       <= '0;
      delta_q     <= '0;
      mode_q      <= '0;
      status_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      tag_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      acc_q       <= acc_d;
      delta_q     <= delta_d;
      mode_q      <= mode_d;
      status_q    <= status_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      tag_out_q   <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_fresh_msg_codec.sv
// Randomised bench for fresh_msg_codec: a message-level model predicts every
// output word, the tag and the status; a negedge monitor compares each cycle.
module tb_fresh_msg_codec;
  localparam int W    = 64;
  localparam int MAXW = 8;
  localparam int DLY  = 10;
  localparam int LW   = 4;
  localparam logic [W-1:0] HINIT = {8{8'hA5}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, in_valid, in_ready, out_valid, out_last, busy, done;
  logic          out_ready = 1'b1;
  logic [LW-1:0] msg_len;
  logic [W-1:0]  cfg_key, ts_sent, ts_now, in_data, out_data, tag_in, tag_out;
  logic [1:0]    cfg_mode, status;

  always #5 clk = ~clk;

  fresh_msg_codec dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len), .cfg_key(cfg_key),
    .cfg_mode(cfg_mode), .ts_sent(ts_sent), .ts_now(ts_now), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .tag_in(tag_in), .tag_out(tag_out),
    .busy(busy), .done(done), .status(status)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } word_t;

  int           checks = 0;
  int           failures = 0;
  word_t        exp_q[$];
  logic [W-1:0] exp_tag = '0;
  logic [1:0]   exp_status = '0;
  bit           expect_done = 0, allow_in = 0, hold_rdy = 0, bp_rdy = 0, rnd_rdy = 0;
  logic [W-1:0] msg_data [16];
  logic [W-1:0] model_words [16];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl3(input logic [W-1:0] x);
    return (x << 3) | (x >> (W - 3));
  endfunction

  function automatic logic [W-1:0] roll(input logic [W-1:0] k);
    logic [W-1:0] fb;
    fb = ((k >> (W-1)) ^ (k >> (W-2)) ^ (k >> (W-4)) ^ (k >> (W-5))) & 64'd1;
    return (k << 1) | fb;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = hold_rdy ? bp_rdy : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (!allow_in) chk("in_ready_gate", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
        else begin
          word_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", 64'(out_last), 64'(e.last));
        end
      end
      if (done) begin
        chk("done_expected", 64'(expect_done), 64'd1);
        chk("status", 64'(status), 64'(exp_status));
        chk("tag_out", tag_out, exp_tag);
        chk("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_msg(input logic [LW-1:0] len, input logic [W-1:0] key, input logic [1:0] mode,
                         input logic [W-1:0] tsent, input logic [W-1:0] tnow, input logic [W-1:0] tagv,
                         input bit tag_good, input bit bp, input int abort_after, input bit hold_start);
    logic [W-1:0] k, acc, w, delta;
    logic [1:0]   st;
    int           n, accepts;
    word_t        e;
    accepts = 0;
    delta = tnow - tsent;
    k = key;
    acc = HINIT;
    if (len == 0 || int'(len) > MAXW) st = 2'b11;
    else if (delta > 64'(DLY)) st = 2'b01;
    else begin
      for (int i = 0; i < int'(len); i++) begin
        w = msg_data[i] ^ k;
        model_words[i] = w;
        e.data = w;
        e.last = (i == int'(len) - 1);
        exp_q.push_back(e);
        acc = rotl3(acc ^ w);
        if (mode[0]) k = roll(k);
      end
      if (tag_good) tagv = acc;
      st = (mode[1] && tagv != acc) ? 2'b10 : 2'b00;
      exp_tag = acc;
    end
    exp_status = st;

    hold_rdy = bp;
    bp_rdy = 1'b0;
    if (bp) begin @(posedge clk); #1; end
    msg_len = len; cfg_key = key; cfg_mode = mode; ts_sent = tsent; ts_now = tnow; tag_in = tagv;
    start = 1'b1;
    allow_in = (st == 2'b00 || st == 2'b10);
    expect_done = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;

    if (allow_in) begin
      fork
        begin
          for (int i = 0; i < int'(len); i++) begin
            int m;
            if (rnd_rdy && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data = msg_data[i];
            m = 0;
            @(negedge clk);
            while (!in_ready && m < 200) begin @(negedge clk); m++; end
            if (!in_ready) begin
              chk("in_accept_timeout", 64'd0, 64'd1);
              in_valid = 1'b0;
              break;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start = ($urandom_range(0, 3) == 0);
            msg_len = LW'($urandom);
            chk("out_valid_latency", 64'(out_valid), 64'd1);
            accepts++;
            if (accepts == abort_after) break;
          end
          start = 1'b0;
        end
        begin
          if (bp) begin
            int m;
            m = 0;
            @(negedge clk);
            while (!out_valid && m < 200) begin @(negedge clk); m++; end
            for (int j = 0; j < 3; j++) begin
              chk("bp_in_ready", 64'(in_ready), 64'd0);
              chk("bp_data_hold", out_data, model_words[0]);
              chk("bp_last_hold", 64'(out_last), 64'd0);
              @(negedge clk);
            end
            bp_rdy = 1'b1;
          end
        end
      join
    end

    if (abort_after > 0 && accepts == abort_after) begin
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_tag_out", tag_out, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_status", 64'(status), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      exp_q.delete();
      exp_tag = '0; exp_status = '0;
      expect_done = 1'b0; allow_in = 1'b0; in_valid = 1'b0; start = 1'b0; hold_rdy = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      return;
    end

    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 400);
    chk("done_seen", 64'(done), 64'd1);
    if (st == 2'b11) chk("done_latency_badlen", 64'(n), 64'd1);
    else if (st == 2'b01) chk("done_latency_stale", 64'(n), 64'd2);
    chk("leftover_words", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    expect_done = 1'b0; allow_in = 1'b0; start = 1'b0; hold_rdy = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("busy_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ts;
    start = 0; msg_len = '0; cfg_key = '0; cfg_mode = '0; ts_sent = '0; ts_now = '0;
    in_valid = 0; in_data = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_status", 64'(status), 64'd0);
    chk("reset_tag", tag_out, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic unmask
    msg_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_msg(4'd1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00, 64'd100, 64'd105, '0, 0, 0, 0, 0);
    chk("basic_word_lit", model_words[0], 64'hF0F0_F0F0_F0F0_F0F0);
    chk("basic_tag_lit", tag_out, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("basic_status_lit", 64'(status), 64'd0);

    // freshness boundary and wrap
    run_msg(4'd1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00, 64'd100, 64'd110, '0, 0, 0, 0, 0);
    chk("delay_eq_status", 64'(status), 64'd0);
    run_msg(4'd1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00, 64'd100, 64'd111, '0, 0, 0, 0, 0);
    chk("stale_status", 64'(status), 64'd1);
    run_msg(4'd1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 64'd5, '0, 0, 0, 0, 0);
    chk("wrap_status", 64'(status), 64'd0);

    // rolling key
    msg_data[0] = '0;
    msg_data[1] = '0;
    run_msg(4'd2, 64'd1, 2'b01, 64'd100, 64'd105, '0, 0, 0, 0, 0);
    chk("roll_word0_lit", model_words[0], 64'd1);
    chk("roll_word1_lit", model_words[1], 64'd2);

    // tag check pass and fail
    msg_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_msg(4'd1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b10, 64'd100, 64'd105, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 0, 0);
    chk("tag_ok_status", 64'(status), 64'd0);
    run_msg(4'd1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b10, 64'd100, 64'd105, 64'd0, 0, 0, 0, 0);
    chk("tag_fail_status", 64'(status), 64'd2);
    chk("tag_fail_tag_lit", tag_out, 64'hAAAA_AAAA_AAAA_AAAA);

    // backpressure, then illegal lengths (len 0 also holds start into DONE)
    for (int i = 0; i < 16; i++) msg_data[i] = {$urandom, $urandom};
    run_msg(4'd3, {$urandom, $urandom}, 2'b01, 64'd7, 64'd9, '0, 0, 1, 0, 0);
    run_msg(4'd0, 64'd5, 2'b00, 64'd100, 64'd105, '0, 0, 0, 0, 1);
    chk("len0_status", 64'(status), 64'd3);
    run_msg(4'd9, 64'd5, 2'b00, 64'd100, 64'd105, '0, 0, 0, 0, 0);
    chk("len9_status", 64'(status), 64'd3);

    // reset mid-stream, then a clean run from the seed
    run_msg(4'd4, {$urandom, $urandom}, 2'b01, 64'd1, 64'd2, '0, 0, 0, 2, 0);
    msg_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_msg(4'd1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00, 64'd100, 64'd105, '0, 0, 0, 0, 0);
    chk("post_reset_tag_lit", tag_out, 64'hAAAA_AAAA_AAAA_AAAA);

    // random messages with random backpressure and input gaps
    rnd_rdy = 1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) msg_data[i] = {$urandom, $urandom};
      ts = {$urandom, $urandom};
      run_msg(LW'($urandom_range(0, 10)), {$urandom, $urandom}, 2'($urandom_range(0, 3)), ts,
              ts + 64'($urandom_range(0, 13)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fresh_msg_codec.md
Name: fresh_msg_codec

Overview:
Parametrised streaming mask/unmask engine for protocol messages (EV/CS/USP registration and authentication). It runs a timestamp freshness check, then streams 1..MAX_WORDS words through an XOR key mask with an optional LFSR-rolled key per word. It accumulates a running tag over the unmasked words and optionally checks that tag against a received one. It replaces the fixed-width, single-cycle xor/hash message builders with a reusable handshaked block.

Parameters:
W, 64, word/key/timestamp width (≥8)
MAX_WORDS, 8, maximum words per message
ACCEPTABLE_DELAY, 10, maximum allowed ts_now - ts_sent
HASH_INIT, {W/8{8'hA5}}, tag accumulator seed

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin message; sampled in IDLE only
msg_len  in  $clog2(MAX_WORDS+1)  word count, sampled with start
cfg_key  in  W  initial mask key, sampled with start
cfg_mode  in  2  bit0 = roll key per word; bit1 = check tag; sampled with start
ts_sent  in  W  sender timestamp, sampled with start
ts_now  in  W  local timestamp, sampled with start
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&in_ready
in_data  in  W  input word
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts
out_data  out  W  masked/unmasked word
out_last  out  1  marks final word of message
tag_in  in  W  expected tag, sampled in TAG state
tag_out  out  W  computed tag, valid with done
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
status  out  2  00 OK, 01 STALE, 10 TAG_FAIL, 11 BAD_LEN; held until next accepted start

Behaviour:
- Reset (rst_n low, any state): FSM→IDLE. out_valid, out_last, out_data, tag_out, done, status, busy = 0. Key, tag accumulator and word counter cleared. in_ready = 0. Takes effect mid-message; partial outputs are discarded.
- States: IDLE, CHECK, STREAM, TAG, DONE.
- IDLE: on start, latch msg_len, cfg_key, cfg_mode, ts_sent, ts_now; clear status; accumulator ← HASH_INIT.
  - msg_len==0 or msg_len>MAX_WORDS → DONE with status 11.
  - Otherwise → CHECK.
- CHECK (1 cycle): delta = (ts_now - ts_sent) mod 2^W, unsigned, so wrap-around is legal.
  - delta > ACCEPTABLE_DELAY → DONE with status 01.
  - Otherwise → STREAM.
  - delta == ACCEPTABLE_DELAY passes.
- STREAM:
  - in_ready = !out_valid || out_ready, combinational; single-entry output register, full throughput.
  - On input accept:
    - out_data ← in_data ^ key; out_valid ← 1 on the next edge (latency 1).
    - out_last ← (word count == msg_len-1).
    - accumulator ← rotl(acc ^ (in_data ^ key), 3).
    - If cfg_mode[0]: key ← {key[W-2:0], key[W-1]^key[W-2]^key[W-4]^key[W-5]}.
  - out_valid && !out_ready: out_data/out_last held stable.
  - Simultaneous input accept and output accept in one cycle: the register reloads, no bubble.
  - When the out_last word is accepted downstream → TAG.
  - No input is accepted after the last word.
- TAG (1 cycle): tag_out ← accumulator.
  - If cfg_mode[1] and tag_in != accumulator → status 10; else status 00.
  - → DONE.
- DONE (1 cycle): done=1 → IDLE. status and tag_out hold.
- start while busy is ignored. start in the DONE cycle is ignored; start is accepted in IDLE.
- All arithmetic is modulo 2^W.

Test Plan:
- Basic unmask: W=64, key=0x0F0F0F0F0F0F0F0F, mode=00, len=1, ts_sent=100, ts_now=105, in_data=0xFFFFFFFFFFFFFFFF → out_data=0xF0F0F0F0F0F0F0F0 with out_last=1 one cycle after accept; tag_out=0xAAAAAAAAAAAAAAAA; done pulse; status=00.
- Freshness boundary: ts_sent=100 with ts_now=110 → STREAM entered. ts_now=111 → status=01, no in_ready, done 2 cycles after start. Wrap case ts_sent=0xFFFFFFFFFFFFFFFC, ts_now=5 (delta 9) → accepted.
- Rolling key: key=1, mode=01, len=2, in_data=0,0 → out_data=0x1 then 0x2.
- Tag check: repeat the basic case with mode=10.
  - tag_in=0xAAAAAAAAAAAAAAAA → status=00.
  - tag_in=0 → status=10, tag_out still 0xAAAAAAAAAAAAAAAA.
- Backpressure/length: len=3, out_ready low for 3 cycles after the first out_valid → in_ready low, out_data held, 3 words emitted in order, last flagged. len=0 or len=9 → status=11.
- Reset mid-stream: assert rst_n low after word 2 of 4 → all outputs 0 immediately. A new start after release runs cleanly from HASH_INIT.
